imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 146 ++++++++++++++
 tb/tb_imem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction memory responder: byte-serial program loader followed by a registered fetch port.
// Latency: one clock from programCounter to fetchedInstruction; a load byte is written on its accepting edge.
// Backpressure: loadReady is high for the whole load phase and low once running; optional misaligned-fetch trap via IMEM_MISALIGN_TRAP_EN.
module imem_responder #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] programCounter,
    output logic [31:0] fetchedInstruction,
    input  logic        loadValid,
    input  logic [7:0]  loadByte,
    input  logic        loadLast,
    output logic        loadReady,
    output logic        loadDone,
    output logic        misalignErr
);

    localparam int              AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0]     NOP        = 32'hC400_0000;
    localparam logic [AW-1:0]   LAST_WADDR = AW'(DEPTH_WORDS - 1);

    typedef enum logic {
        sLoad = 1'b0,
        sRun  = 1'b1
    } state_t;

    state_t          state_q;
    logic [1:0]      lane_q;
    logic [AW-1:0]   waddr_q;
    logic [23:0]     buf_q;
    logic [31:0]     fetch_q;

    // Instruction storage; deliberately never reset so a reload only overwrites what it touches.
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            load_fire;
    logic            wr_en;
    logic            done_d;
    logic [31:0]     word_d;
    logic [AW-1:0]   pc_idx;
    logic            pc_oob;
    logic            misalign_hit;
    logic [31:0]     fetch_d;

    // Handshake and word assembly: lanes below the current one come from the buffer, lanes above are zero.
    always_comb begin
        load_fire = (state_q == sLoad) && loadValid;
        word_d    = '0;
        case (lane_q)
            2'd0:    word_d = {24'h0, loadByte};
            2'd1:    word_d = {16'h0, loadByte, buf_q[7:0]};
            2'd2:    word_d = {8'h0, loadByte, buf_q[15:0]};
            default: word_d = {loadByte, buf_q[23:0]};
        endcase
        wr_en  = load_fire && ((lane_q == 2'd3) || loadLast);
        done_d = wr_en && (loadLast || (waddr_q == LAST_WADDR));
    end

    // Fetch address decode: out-of-range word indices (and, when trapping, misaligned PCs) yield NOP.
    always_comb begin
        pc_idx = programCounter[AW+1:2];
        pc_oob = |programCounter[31:AW+2];
`ifdef IMEM_MISALIGN_TRAP_EN
        misalign_hit = |programCounter[1:0];
`else
        misalign_hit = 1'b0;
`endif
        fetch_d = (pc_oob || misalign_hit) ? NOP : mem_q[pc_idx];
    end

`ifndef IMEM_MISALIGN_TRAP_EN
    // The byte offset within a word has no meaning without the trap.
    logic unused_pc_lo;
    assign unused_pc_lo = ^programCounter[1:0];
`endif

    // Storage write port: one complete (or zero-padded final) word per write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[waddr_q] <= word_d;
        end
    end

`ifdef IMEM_MISALIGN_TRAP_EN
    logic misalign_q;

    // Sticky misalignment flag, only armed while serving fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if ((state_q == sRun) && misalign_hit) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalignErr = misalign_q;
`else
    assign misalignErr = 1'b0;
`endif

    // Load/run FSM with registered fetch output, lane counter and write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= sLoad;
            fetch_q <= NOP;
            lane_q  <= 2'd0;
            waddr_q <= '0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                sLoad: begin
                    fetch_q <= NOP;
                    if (load_fire) begin
                        case (lane_q)
                            2'd0:    buf_q[7:0]   <= loadByte;
                            2'd1:    buf_q[15:8]  <= loadByte;
                            2'd2:    buf_q[23:16] <= loadByte;
                            default: buf_q        <= buf_q;
                        endcase
                        if (wr_en) begin
                            lane_q <= 2'd0;
                            // The pointer stops at the top word instead of wrapping.
                            if (waddr_q != LAST_WADDR) begin
                                waddr_q <= waddr_q + 1'b1;
                            end
                        end else begin
                            lane_q <= lane_q + 2'd1;
                        end
                        if (done_d) begin
                            state_q <= sRun;
                        end
                    end
                end
                default: begin
                    fetch_q <= fetch_d;
                end
            endcase
        end
    end

    assign fetchedInstruction = fetch_q;
    assign loadReady          = (state_q == sLoad);
    assign loadDone           = (state_q == sRun);

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'hC400_0000;

    logic        clk;
    logic        rst;

    logic [31:0] pc_a;
    logic [31:0] fi_a;
    logic        lv_a;
    logic [7:0]  lb_a;
    logic        ll_a;
    logic        lr_a;
    logic        ld_a;
    logic        me_a;

    logic [31:0] pc_b;
    logic [31:0] fi_b;
    logic        lv_b;
    logic [7:0]  lb_b;
    logic        ll_b;
    logic        lr_b;
    logic        ld_b;
    logic        me_b;

    int tests_run;
    int tests_failed;

    imem_responder dut_a (
        .clk                (clk),
        .rst                (rst),
        .programCounter     (pc_a),
        .fetchedInstruction (fi_a),
        .loadValid          (lv_a),
        .loadByte           (lb_a),
        .loadLast           (ll_a),
        .loadReady          (lr_a),
        .loadDone           (ld_a),
        .misalignErr        (me_a)
    );

    imem_responder #(.DEPTH_WORDS(4)) dut_b (
        .clk                (clk),
        .rst                (rst),
        .programCounter     (pc_b),
        .fetchedInstruction (fi_b),
        .loadValid          (lv_b),
        .loadByte           (lb_b),
        .loadLast           (ll_b),
        .loadReady          (lr_b),
        .loadDone           (ld_b),
        .misalignErr        (me_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b, input logic last);
        lv_a = 1'b1;
        lb_a = b;
        ll_a = last;
        tick();
        lv_a = 1'b0;
        ll_a = 1'b0;
        lb_a = 8'hFF;
    endtask

    task automatic fetch_a(input logic [31:0] pc);
        pc_a = pc;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst  = 1'b0;
        pc_a = '0; lv_a = 1'b0; lb_a = '0; ll_a = 1'b0;
        pc_b = '0; lv_b = 1'b0; lb_b = '0; ll_b = 1'b0;

        // Reset values
        #1 rst = 1'b1;
        #1;
        check("rst_fetch", fi_a, NOP);
        check("rst_ready", {31'b0, lr_a}, 32'd1);
        check("rst_done",  {31'b0, ld_a}, 32'd0);
        check("rst_merr",  {31'b0, me_a}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Fetch during load returns NOP
        fetch_a(32'h0);
        check("load_fetch_nop", fi_a, NOP);

        // Load two words with idle gaps between bytes
        send_a(8'h78, 1'b0); tick();
        send_a(8'h56, 1'b0); tick(); tick();
        send_a(8'h34, 1'b0);
        send_a(8'h12, 1'b0); tick();
        check("mid_load_done", {31'b0, ld_a}, 32'd0);
        send_a(8'hEF, 1'b0); tick();
        send_a(8'hBE, 1'b0);
        send_a(8'hAD, 1'b0); tick();
        check("before_last_done", {31'b0, ld_a}, 32'd0);
        send_a(8'hDE, 1'b1);
        check("last_done",  {31'b0, ld_a}, 32'd1);
        check("last_ready", {31'b0, lr_a}, 32'd0);

        fetch_a(32'h0);
        check("run_pc0", fi_a, 32'h1234_5678);
        fetch_a(32'h4);
        check("run_pc4", fi_a, 32'hDEAD_BEEF);

        // Misaligned fetch
        fetch_a(32'h2);
`ifdef IMEM_MISALIGN_TRAP_EN
        check("misalign_pc2", fi_a, NOP);
        check("misalign_flag", {31'b0, me_a}, 32'd1);
        fetch_a(32'h0);
        check("misalign_sticky", {31'b0, me_a}, 32'd1);
        check("after_misalign_pc0", fi_a, 32'h1234_5678);
`else
        check("misalign_pc2", fi_a, 32'h1234_5678);
        check("misalign_flag", {31'b0, me_a}, 32'd0);
        fetch_a(32'h6);
        check("misalign_pc6", fi_a, 32'hDEAD_BEEF);
`endif

        // Out-of-range word indices
        fetch_a(32'h400);
        check("oob_400", fi_a, NOP);
        fetch_a(32'h8000_0004);
        check("oob_msb", fi_a, NOP);

        // Load bytes in run state are ignored
        lv_a = 1'b1; lb_a = 8'h99; ll_a = 1'b1; pc_a = 32'h8;
        tick();
        lv_a = 1'b0; ll_a = 1'b0;
        fetch_a(32'h0);
        check("run_ignore_load", fi_a, 32'h1234_5678);
        check("run_still_done", {31'b0, ld_a}, 32'd1);

        // Reset mid-run
        rst = 1'b1;
        #1;
        check("rst_run_fetch", fi_a, NOP);
        check("rst_run_done",  {31'b0, ld_a}, 32'd0);
        check("rst_run_merr",  {31'b0, me_a}, 32'd0);
        tick();
        rst = 1'b0;

        // Short final word is zero-padded
        send_a(8'h01, 1'b0);
        send_a(8'h02, 1'b0);
        send_a(8'h03, 1'b0);
        send_a(8'h04, 1'b0);
        send_a(8'hAA, 1'b1);
        check("short_done", {31'b0, ld_a}, 32'd1);
        fetch_a(32'h4);
        check("short_word1", fi_a, 32'h0000_00AA);
        fetch_a(32'h0);
        check("short_word0", fi_a, 32'h0403_0201);

        // Reset after two bytes of a load, then reload
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        rst = 1'b1;
        #1;
        check("midload_rst_ready", {31'b0, lr_a}, 32'd1);
        tick();
        rst = 1'b0;
        send_a(8'h9A, 1'b0);
        send_a(8'hBC, 1'b1);
        check("reload_done", {31'b0, ld_a}, 32'd1);
        fetch_a(32'h0);
        check("reload_word0", fi_a, 32'h0000_BC9A);
        fetch_a(32'h4);
        check("reload_word1_kept", fi_a, 32'h0000_00AA);

        // Small instance fills without loadLast
        for (int i = 0; i < 16; i++) begin
            lv_b = 1'b1;
            lb_b = 8'(i + 1);
            tick();
            if (i == 14) check("b_byte15_done", {31'b0, ld_b}, 32'd0);
        end
        lv_b = 1'b0;
        check("b_byte16_done", {31'b0, ld_b}, 32'd1);
        pc_b = 32'h10;
        tick();
        check("b_oob_10", fi_b, NOP);
        pc_b = 32'hC;
        tick();
        check("b_word3", fi_b, 32'h100F_0E0D);
        pc_b = 32'h0;
        tick();
        check("b_word0", fi_b, 32'h0403_0201);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
